// File: rtl/seq_mult_pkg.sv
// Shared definitions for the handshaked sequential multiplier:
// FSM state encoding, the legal slice widths and the cycle-count helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Multiplier bits that may be retired per compute cycle
    localparam int unsigned LEGAL_BPC [3] = '{1, 2, 4};

    // Number of compute cycles: ceil(width / bpc)
    function automatic int calc_cycles(input int width, input int bpc);
        return (width + bpc - 1) / bpc;
    endfunction

    function automatic bit bpc_is_legal(input int bpc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (int'(LEGAL_BPC[i]) == bpc) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_mult_pp_step.sv
// One partial-product step: acc + (factor1 * slice) << shift.
// Purely combinational; the top reuses this single instance every cycle.
module seq_mult_pp_step #(
    parameter int BIT_WIDTH      = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHIFT_W        = 5
) (
    input  logic [2*BIT_WIDTH-1:0]    acc_i,
    input  logic [BIT_WIDTH-1:0]      factor1_i,
    input  logic [BITS_PER_CYCLE-1:0] slice_i,
    input  logic [SHIFT_W-1:0]        shift_i,
    output logic [2*BIT_WIDTH-1:0]    acc_o
);

    logic [2*BIT_WIDTH-1:0] f1_ext;
    logic [2*BIT_WIDTH-1:0] slice_ext;
    logic [2*BIT_WIDTH-1:0] pp;

    assign f1_ext    = {{BIT_WIDTH{1'b0}}, factor1_i};
    assign slice_ext = {{(2*BIT_WIDTH-BITS_PER_CYCLE){1'b0}}, slice_i};
    assign pp        = (f1_ext * slice_ext) << shift_i;
    assign acc_o     = acc_i + pp;

endmodule

// File: rtl/seq_multiplier_hs.sv
// Sequential shift-add multiplier with valid/ready handshakes on operands
// and result, BITS_PER_CYCLE multiplier bits retired per compute cycle and
// an enable-based stall. Signed operation (signed_mode port) is compiled in
// only when SEQ_MULT_SIGNED_EN is defined; otherwise the unit is unsigned.
module seq_multiplier_hs
    import seq_mult_pkg::*;
#(
    parameter int BIT_WIDTH      = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   factor1,
    input  logic [BIT_WIDTH-1:0]   factor2,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                   signed_mode,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*BIT_WIDTH-1:0] product,
    output logic                   busy
);

    localparam int CYCLES  = calc_cycles(BIT_WIDTH, BITS_PER_CYCLE);
    localparam int F2W     = CYCLES * BITS_PER_CYCLE;
    localparam int CNTW    = $clog2(CYCLES + 1);
    localparam int SHIFT_W = $clog2(2 * BIT_WIDTH) + 1;
    localparam logic [CNTW-1:0] CYCLES_C = CNTW'(CYCLES);

    if (BIT_WIDTH < 2 || BIT_WIDTH > 32) begin : g_bad_width
        $error("seq_multiplier_hs: BIT_WIDTH must be in 2..32");
    end
    if (!bpc_is_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
        $error("seq_multiplier_hs: BITS_PER_CYCLE must be 1, 2 or 4");
    end
    if (BITS_PER_CYCLE > BIT_WIDTH) begin : g_bpc_too_wide
        $error("seq_multiplier_hs: BITS_PER_CYCLE must not exceed BIT_WIDTH");
    end

    state_t                 state_q;
    logic [BIT_WIDTH-1:0]   f1_q;
    logic [F2W-1:0]         f2_q;
    logic [2*BIT_WIDTH-1:0] acc_q;
    logic [CNTW-1:0]        cnt_q;
    logic [2*BIT_WIDTH-1:0] product_q;
    logic                   out_valid_q;
    logic                   in_ready_q;
    logic                   busy_q;

    logic [BIT_WIDTH-1:0]   f1_d;
    logic [BIT_WIDTH-1:0]   f2_d;
    logic [2*BIT_WIDTH-1:0] acc_d;
    logic [2*BIT_WIDTH-1:0] result_d;
    logic [CNTW-1:0]        step;
    logic [SHIFT_W-1:0]     shift;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;
    logic neg_d;

    // Convert signed operands to magnitudes and remember the result sign
    always_comb begin
        f1_d  = factor1;
        f2_d  = factor2;
        neg_d = 1'b0;
        if (signed_mode) begin
            if (factor1[BIT_WIDTH-1]) f1_d = -factor1;
            if (factor2[BIT_WIDTH-1]) f2_d = -factor2;
            neg_d = factor1[BIT_WIDTH-1] ^ factor2[BIT_WIDTH-1];
        end
    end

    // Sign fix-up is applied on the way into the product register
    assign result_d = neg_q ? -acc_d : acc_d;
`else
    assign f1_d     = factor1;
    assign f2_d     = factor2;
    assign result_d = acc_d;
`endif

    // Steps already done select how far the current partial product shifts
    assign step  = CYCLES_C - cnt_q;
    assign shift = SHIFT_W'(step) * SHIFT_W'(BITS_PER_CYCLE);

    seq_mult_pp_step #(
        .BIT_WIDTH      (BIT_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHIFT_W        (SHIFT_W)
    ) u_pp_step (
        .acc_i     (acc_q),
        .factor1_i (f1_q),
        .slice_i   (f2_q[BITS_PER_CYCLE-1:0]),
        .shift_i   (shift),
        .acc_o     (acc_d)
    );

    // FSM, operand capture, step counter and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            f1_q        <= '0;
            f2_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        f1_q       <= f1_d;
                        f2_q       <= F2W'(f2_d);
                        acc_q      <= '0;
                        cnt_q      <= CYCLES_C;
                        state_q    <= ST_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
                        neg_q      <= neg_d;
`endif
                    end
                end
                ST_CALC: begin
                    if (enable) begin
                        acc_q <= acc_d;
                        f2_q  <= f2_q >> BITS_PER_CYCLE;
                        cnt_q <= cnt_q - CNTW'(1);
                        if (cnt_q == CNTW'(1)) begin
                            product_q   <= result_d;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: doc/seq_multiplier_hs.md
Name: seq_multiplier_hs

Overview:
- Parametrised successor to the sequential shift-add multiplier.
- Adds a valid/ready handshake on operands and result, and a configurable number of multiplier bits retired per cycle.
- Adds an enable-based stall and optional signed operation.
- Standalone arithmetic unit for datapaths that tolerate multi-cycle latency in exchange for small area.

Parameters:
- BIT_WIDTH, 8, operand width; legal range 2..32.
- BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle; legal values {1,2,4}, must be ≤ BIT_WIDTH.
- Any illegal value raises an elaboration-time error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when low in CALC, freezes all state (stall).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  unit can accept operands; high only in IDLE.
- factor1  in  BIT_WIDTH  multiplicand.
- factor2  in  BIT_WIDTH  multiplier.
- signed_mode  in  1  treat operands as two's complement; present only with SEQ_MULT_SIGNED_EN.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*BIT_WIDTH  result.
- busy  out  1  high in CALC.

Behaviour:
- Cycle count: CYCLES = ceil(BIT_WIDTH/BITS_PER_CYCLE). If BITS_PER_CYCLE does not divide BIT_WIDTH, the multiplier is zero-extended to CYCLES*BITS_PER_CYCLE bits.
- Reset (reset=0, async): state IDLE; in_ready=1, out_valid=0, busy=0, product=0; operand and counter registers cleared.
- Reset mid-operation: the operation is aborted, no result is produced, and all outputs return to their reset values immediately.
- IDLE: in_ready=1.
  - Accept on the rising edge where in_valid & in_ready.
  - At accept: latch factor1 and factor2 (and signed_mode), clear the accumulator, load the counter with CYCLES, go to CALC.
  - The enable input has no effect in IDLE.
- CALC: busy=1, in_ready=0.
  - On each edge with enable=1: acc += factor1_reg * factor2_reg[slice] << (step*BITS_PER_CYCLE); counter decrements.
  - When the last step completes, go to DONE.
  - On edges with enable=0: no state changes.
- Latency: with enable held high, out_valid rises exactly CYCLES edges after the accept edge.
- DONE: out_valid=1 and product holds the final value, stable until the handshake.
  - On the edge with out_valid & out_ready: go to IDLE, out_valid=0.
  - product retains its value in IDLE until the next result is written.
- No overlap: new operands cannot be accepted before the result is consumed.
  - Minimum issue interval is CYCLES+2 cycles: 1 accept + CYCLES compute + 1 result handshake.
  - A new accept is possible on the first IDLE cycle after the result handshake.
- Arithmetic: product is the exact 2*BIT_WIDTH-bit result; overflow cannot occur. Unsigned by default.
- Operands are sampled only at accept; changes to factor1/factor2 afterwards are ignored.
- product is updated only at the DONE transition, never with partial sums.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - The signed_mode port exists and is latched at accept.
  - When it is 1, both operands are converted to magnitudes; the result is negated if the signs differ.
  - Result is two's complement over 2*BIT_WIDTH bits.
  - Most-negative × most-negative gives +2^(2*BIT_WIDTH-2) exactly.
  - Latency is unchanged; the sign fix-up is folded into the DONE transition.
- Undefined: the signed_mode port is absent and all operation is unsigned. Logic area is reduced.

Decomposition:
- Package seq_mult_pkg contains:
  - state enum typedef (IDLE, CALC, DONE);
  - function calc_cycles(width, bpc) returning ceil(width/bpc);
  - the legal BITS_PER_CYCLE set.
- Sub-module seq_mult_pp_step: the combinational partial-product step, factor1 × BITS_PER_CYCLE-bit slice, shifted and added to acc. It is instantiated once and reused every cycle.
- FSM, counter and handshake stay in the top module.

Test Plan:
- BIT_WIDTH=8, BPC=1: accept 13×11 with enable=1, out_ready=1 → out_valid high exactly 8 edges after accept, product=143, returns to IDLE next edge.
- 255×255, then 0×200 back-to-back with in_valid held → products 65025 then 0; in_ready low throughout CALC/DONE; issue interval 10 cycles.
- Stall and backpressure: drop enable for 3 cycles mid-CALC and hold out_ready=0 for 5 cycles in DONE → out_valid is delayed exactly 3 cycles; product stays stable and out_valid stays high until out_ready.
- BIT_WIDTH=8, BPC=2 with 200×3 → product=600 after 4 cycles. BIT_WIDTH=6, BPC=4 with 63×63 → product=3969 after 2 cycles.
- Drive reset low mid-CALC at step 4 → out_valid=0, product=0, in_ready=1 asynchronously; the next operation 7×9=63 completes normally.
- With SEQ_MULT_SIGNED_EN, BIT_WIDTH=8, signed_mode=1:
  - -3×5 → 0xFFF1;
  - -128×-128 → 16384;
  - 127×-1 → 0xFF81.
  - With signed_mode=0, 0xFD×5 → 1265.
